// File: rtl/z80_mem_mapper.sv
// z80_mem_mapper
//   Memory/IO mapper for the nano-z80 core. The 64 KB CPU space is split into
//   four 16 KB windows, each mapped onto a programmable physical RAM page, with
//   a boot-ROM overlay on window 0 (reads only). IO ports are decoded into
//   one-hot peripheral selects plus an internal register window (0xF0-0xFF).
//   A small FSM stretches each access with a class-dependent number of wait
//   clocks on wait_n.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   addr_i, data_i       CPU address and write data
//   mreq_n .. m1_n       Z80 bus strobes (active-low)
//   data_o               mapper register readback (0 unless reading the mapper)
//   phys_addr            {page[window], addr_i[13:0]}
//   ram_cs, rom_cs       memory selects
//   io_cs                one-hot peripheral selects (port range n*16 .. n*16+15)
//   mapper_cs            internal register window selected
//   wait_n               Z80 WAIT, active-low
//   dbg_state_o          wait FSM state (0 IDLE, 1 WAIT, 2 HOLD)
//
// Bus handshake: an access is requested while mreq_n=0 or a valid IO cycle
// (ioreq_n=0, m1_n=1) is on the bus. The first clock edge that sees a request
// after an edge that saw none starts the access; wait_n then stays low for
// exactly the class wait count, and the mapper is re-armed only after the
// request has been observed low at a clock edge.
module z80_mem_mapper #(
  parameter int PAGE_BITS = 4,
  parameter int NUM_IO_CS = 4,
  parameter int ROM_WAIT  = 1,
  parameter int RAM_WAIT  = 0,
  parameter int IO_WAIT   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [15:0]            addr_i,
  input  logic [7:0]             data_i,
  input  logic                   mreq_n,
  input  logic                   ioreq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   m1_n,
  output logic [7:0]             data_o,
  output logic [PAGE_BITS+13:0]  phys_addr,
  output logic                   ram_cs,
  output logic                   rom_cs,
  output logic [NUM_IO_CS-1:0]   io_cs,
  output logic                   mapper_cs,
  output logic                   wait_n,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
  localparam logic [3:0] IO_W  = 4'(IO_WAIT);

  // Mapper registers
  logic [PAGE_BITS-1:0] page_q [4];
  logic [3:0]           wp_q;
  logic                 overlay_q;
  logic                 wr_seen_q;

  // Wait FSM
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       req_q;

  // Bus decode
  logic       io_valid;
  logic       mem_req;
  logic       req;
  logic       start;
  logic [1:0] win;
  logic       io_wr;
  logic       reg_wr;
  logic [3:0] class_wait;
  logic [7:0] page_rd;
  logic       unused_data;

  assign io_valid  = !ioreq_n && m1_n;
  assign mem_req   = !mreq_n;
  assign req       = mem_req || io_valid;
  assign start     = req && !req_q;
  assign win       = addr_i[15:14];
  assign mapper_cs = io_valid && (addr_i[7:4] == 4'hF);

  // Only part of the write data is stored, depending on PAGE_BITS.
  assign unused_data = ^data_i;

  always_comb begin
    io_cs = '0;
    for (int n = 0; n < NUM_IO_CS; n++) begin
      io_cs[n] = io_valid && (addr_i[7:4] == 4'(n));
    end
  end

  // ROM overlay only catches reads; writes fall through to the RAM page so the
  // boot code can build a shadow copy under the ROM.
  assign rom_cs    = mem_req && (win == 2'd0) && overlay_q && wr_n;
  assign ram_cs    = mem_req && !rom_cs && !(!wr_n && wp_q[win]);
  assign phys_addr = {page_q[win], addr_i[13:0]};

  always_comb begin
    page_rd                  = '0;
    page_rd[PAGE_BITS-1:0]   = page_q[addr_i[1:0]];
    page_rd[7]               = wp_q[addr_i[1:0]];
  end

  always_comb begin
    data_o = '0;
    if (mapper_cs && !rd_n) begin
      case (addr_i[3:0])
        4'h0, 4'h1, 4'h2, 4'h3: data_o = page_rd;
        4'hE:                   data_o = {7'b0, overlay_q};
        default:                data_o = '0;
      endcase
    end
  end

  // A write is committed on the first edge of an IO write cycle only; the
  // wr_seen flag blocks the remaining edges of a stretched cycle.
  assign io_wr  = io_valid && !wr_n;
  assign reg_wr = io_wr && !wr_seen_q && mapper_cs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < 4; w++) begin
        page_q[w] <= PAGE_BITS'(w);
      end
      wp_q      <= '0;
      overlay_q <= 1'b1;
      wr_seen_q <= 1'b0;
    end else begin
      wr_seen_q <= io_wr;
      if (reg_wr) begin
        if (addr_i[3:2] == 2'b00) begin
          page_q[addr_i[1:0]] <= data_i[PAGE_BITS-1:0];
          wp_q[addr_i[1:0]]   <= data_i[7];
        end else if (addr_i[3:0] == 4'hE) begin
          overlay_q <= data_i[0];
        end
      end
    end
  end

  // Write-protected RAM writes still count as RAM accesses for timing.
  always_comb begin
    class_wait = 4'd0;
    if (rom_cs)          class_wait = ROM_W;
    else if (mem_req)    class_wait = RAM_W;
    else if (|io_cs)     class_wait = IO_W;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = class_wait;
          state_d = (class_wait == 4'd0) ? ST_HOLD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req)               state_d = ST_IDLE;
        else if (cnt_q <= 4'd1) state_d = ST_HOLD;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      ST_HOLD: begin
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req;
    end
  end

  assign wait_n      = (state_q != ST_WAIT);
  assign dbg_state_o = state_q;

endmodule
